// File: rtl/regfile_rw.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rw
// Description : RISC-V integer register file, two registered read ports, one
//               write port, post-reset clear sweep so the array is RAM-inferable.
//               Optional same-edge write-to-read bypass: REGFILE_RW_BYPASS_EN.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_rw #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   io_rf_ra,
    input  logic [AW-1:0]   io_rf_rb,
    output logic [XLEN-1:0] io_rf_rsa,
    output logic [XLEN-1:0] io_rf_rsb,
    input  logic            io_rf_we,
    input  logic [AW-1:0]   io_rf_wa,
    input  logic [XLEN-1:0] io_rf_wd,
    output logic            io_rf_ready
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] C_LAST_IDX = AW'(NREG - 1);

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_ready;
    logic [XLEN-1:0] r_rsa;
    logic [XLEN-1:0] r_rsb;
    logic [XLEN-1:0] r_mem [NREG];

    logic            w_clear;
    logic            w_run_we;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_wa;
    logic [XLEN-1:0] w_mem_wd;
    logic [XLEN-1:0] w_rda;
    logic [XLEN-1:0] w_rdb;

    // The sweep borrows the single write port, so user writes are shut out until RUN.
    assign w_clear  = (r_state == ST_CLEAR);
    assign w_run_we = !w_clear && io_rf_we && (io_rf_wa != '0);
    assign w_mem_we = w_clear || w_run_we;
    assign w_mem_wa = w_clear ? r_cnt : io_rf_wa;
    assign w_mem_wd = w_clear ? '0 : io_rf_wd;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

    always_comb begin
        w_rda = (io_rf_ra == '0) ? '0 : r_mem[io_rf_ra];
        w_rdb = (io_rf_rb == '0) ? '0 : r_mem[io_rf_rb];
`ifdef REGFILE_RW_BYPASS_EN
        if (w_run_we && (io_rf_ra == io_rf_wa)) begin
            w_rda = io_rf_wd;
        end
        if (w_run_we && (io_rf_rb == io_rf_wa)) begin
            w_rdb = io_rf_wd;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= AW'(1);
            r_ready <= 1'b0;
            r_rsa   <= '0;
            r_rsb   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_rsa <= '0;
                    r_rsb <= '0;
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == C_LAST_IDX) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_rsa <= w_rda;
                    r_rsb <= w_rdb;
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= AW'(1);
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign io_rf_rsa   = r_rsa;
    assign io_rf_rsb   = r_rsb;
    assign io_rf_ready = r_ready;

endmodule
`default_nettype wire
